// File: rtl/prime_pkg.sv
// Shared state encoding and sizing constants for the prime query arbiter and its
// trial-division remainder unit.
package prime_pkg;

    localparam int unsigned DEFAULT_WIDTH = 10;
    localparam int unsigned COUNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DIV,
        EVAL
    } state_e;

endpackage

// File: rtl/prime_modunit.sv
// Restoring-division remainder unit: computes i_n mod i_d one quotient bit per cycle,
// pulsing o_done exactly WIDTH cycles after i_start with o_rem held until the next start.
module prime_modunit
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rem
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [WIDTH-1:0] w_rem_in;
    logic [WIDTH-1:0] w_quo_in;
    logic [WIDTH:0]   w_part;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;

    // The first quotient bit resolves on the start edge, so WIDTH-1 further steps remain.
    always_comb begin
        w_rem_in  = i_start ? '0 : r_rem;
        w_quo_in  = i_start ? i_n : r_quo;
        w_part    = {w_rem_in, w_quo_in[WIDTH-1]};
        w_diff    = w_part - {1'b0, i_d};
        w_qbit    = ~w_diff[WIDTH];
        w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem <= w_rem_nxt;
                r_quo <= {w_quo_in[WIDTH-2:0], w_qbit};
                r_cnt <= CNT_W'(WIDTH - 1);
            end else if (r_cnt != '0) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= {w_quo_in[WIDTH-2:0], w_qbit};
                r_cnt  <= r_cnt - CNT_W'(1);
                r_done <= (r_cnt == CNT_W'(1));
            end
        end
    end

    assign o_done = r_done;
    assign o_rem  = r_rem;

endmodule

// File: rtl/prime_query_arbiter.sv
// Round-robin scheduler sharing one trial-division datapath between two requesters;
// returns a tagged one-cycle primality verdict and keeps saturating per-port prime counts.
module prime_query_arbiter
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               i_sys_clk,
    input  logic               i_reset,
    input  logic               i_req0,
    input  logic               i_req1,
    input  logic [WIDTH-1:0]   i_num0,
    input  logic [WIDTH-1:0]   i_num1,
    output logic               o_ack0,
    output logic               o_ack1,
    output logic               o_done,
    output logic               o_done_id,
    output logic               o_prime,
    output logic               o_busy,
    output logic [COUNT_W-1:0] o_prime_count0,
    output logic [COUNT_W-1:0] o_prime_count1
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    state_e             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_n, w_n_nxt;
    logic [WIDTH-1:0]   r_d, w_d_nxt;
    logic               r_id, w_id_nxt;
    logic               r_last, w_last_nxt;
    logic               r_ack0, w_ack0_nxt;
    logic               r_ack1, w_ack1_nxt;
    logic               r_done, w_done_nxt;
    logic               r_done_id, w_done_id_nxt;
    logic               r_prime, w_prime_nxt;
    logic               r_busy, w_busy_nxt;
    logic [COUNT_W-1:0] r_cnt0, w_cnt0_nxt;
    logic [COUNT_W-1:0] r_cnt1, w_cnt1_nxt;

    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_start;
    logic               w_div_done;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_sq;
    logic               w_verdict;
    logic               w_is_prime;

    prime_modunit #(
        .WIDTH (WIDTH)
    ) u_modunit (
        .i_clk   (i_sys_clk),
        .i_rst   (i_reset),
        .i_start (w_start),
        .i_n     (r_n),
        .i_d     (r_d),
        .o_done  (w_div_done),
        .o_rem   (w_rem)
    );

    // On a tie the port that did not win last time is granted.
    assign w_gnt0 = i_req0 & (~i_req1 | r_last);
    assign w_gnt1 = i_req1 & (~i_req0 | ~r_last);
    assign w_sq   = {{WIDTH{1'b0}}, r_d} * {{WIDTH{1'b0}}, r_d};

    always_comb begin
        w_state_nxt   = r_state;
        w_n_nxt       = r_n;
        w_d_nxt       = r_d;
        w_id_nxt      = r_id;
        w_last_nxt    = r_last;
        w_ack0_nxt    = 1'b0;
        w_ack1_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_prime_nxt   = r_prime;
        w_busy_nxt    = r_busy;
        w_cnt0_nxt    = r_cnt0;
        w_cnt1_nxt    = r_cnt1;
        w_start       = 1'b0;
        w_verdict     = 1'b0;
        w_is_prime    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_gnt0 | w_gnt1) begin
                    w_n_nxt     = w_gnt1 ? i_num1 : i_num0;
                    w_id_nxt    = w_gnt1;
                    w_last_nxt  = w_gnt1;
                    w_ack0_nxt  = w_gnt0;
                    w_ack1_nxt  = w_gnt1;
                    w_d_nxt     = WIDTH'(2);
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (r_n < WIDTH'(2)) begin
                    w_verdict = 1'b1;
                end else if (w_sq > {{WIDTH{1'b0}}, r_n}) begin
                    w_verdict  = 1'b1;
                    w_is_prime = 1'b1;
                end else begin
                    w_start     = 1'b1;
                    w_state_nxt = DIV;
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (w_rem == '0) begin
                    w_verdict = 1'b1;
                end else begin
                    w_d_nxt     = r_d + WIDTH'(1);
                    w_state_nxt = CHECK;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_verdict) begin
            w_done_nxt    = 1'b1;
            w_prime_nxt   = w_is_prime;
            w_done_id_nxt = r_id;
            w_busy_nxt    = 1'b0;
            w_state_nxt   = IDLE;
            if (w_is_prime && !r_id && r_cnt0 != COUNT_MAX) begin
                w_cnt0_nxt = r_cnt0 + COUNT_W'(1);
            end
            if (w_is_prime && r_id && r_cnt1 != COUNT_MAX) begin
                w_cnt1_nxt = r_cnt1 + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_n       <= '0;
            r_d       <= WIDTH'(2);
            r_id      <= 1'b0;
            r_last    <= 1'b1;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_prime   <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_n       <= w_n_nxt;
            r_d       <= w_d_nxt;
            r_id      <= w_id_nxt;
            r_last    <= w_last_nxt;
            r_ack0    <= w_ack0_nxt;
            r_ack1    <= w_ack1_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_prime   <= w_prime_nxt;
            r_busy    <= w_busy_nxt;
            r_cnt0    <= w_cnt0_nxt;
            r_cnt1    <= w_cnt1_nxt;
        end
    end

    assign o_ack0         = r_ack0;
    assign o_ack1         = r_ack1;
    assign o_done         = r_done;
    assign o_done_id      = r_done_id;
    assign o_prime        = r_prime;
    assign o_busy         = r_busy;
    assign o_prime_count0 = r_cnt0;
    assign o_prime_count1 = r_cnt1;

endmodule

// File: doc/prime_query_arbiter.md
# prime_query_arbiter

Shared primality-test scheduler. Two requesters submit WIDTH-bit candidates; the block grants the single trial-division datapath round-robin and runs divisors d = 2, 3, … until d·d > N or a zero remainder. It returns a one-cycle verdict tagged with the requester ID and keeps a per-port count of primes found. It sits between the number-sweep front ends and the shared divider. It replaces per-sweeper prime engines.

## Interface
- WIDTH, 10, candidate and divisor width
- SysClk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- Req0, Req1  in  1  request valid; hold until matching Ack
- Num0, Num1  in  WIDTH  candidate; stable while Req high
- Ack0, Ack1  out  1  one-cycle pulse: request accepted, Num latched
- Done  out  1  one-cycle pulse: verdict valid
- DoneId  out  1  port that owns the verdict
- Prime  out  1  verdict, valid only with Done
- Busy  out  1  high from accept until Done
- PrimeCount0, PrimeCount1  out  8  per-port primes found, saturating at 255

## Operation
- Reset values: all outputs 0, state IDLE, d = 2, LastGrant = 1 (port 0 wins the first tie).
- States: IDLE, CHECK, DIV, EVAL.
- IDLE: sample Req0 and Req1.
  - One request high: grant that port.
  - Both high: grant the port != LastGrant.
  - On grant: latch N and the port ID, update LastGrant, pulse Ack for that port, set d = 2, go to CHECK.
- CHECK:
  - N < 2: verdict not prime.
  - d·d > N (2·WIDTH-bit compare): verdict prime.
  - Otherwise pulse start to the divider and go to DIV.
- DIV: wait for divider done (exactly WIDTH cycles), then go to EVAL.
- EVAL:
  - rem == 0: verdict not prime.
  - Otherwise d = d + 1, go to CHECK.
- Verdict edge:
  - Done = 1, Prime and DoneId set, Busy = 0, state to IDLE.
  - The matching PrimeCount increments if Prime = 1 and the count is < 255.
- Req still high after Ack is not a new request. The requester must drop Req the cycle it sees Ack. A request re-raised later is queued normally.
- d never exceeds 2^(WIDTH/2)+1, so no overflow in d or d·d.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - The in-flight verdict is lost and no Done is produced.
  - Counts clear.

## Timing
- Accept edge e: Ack and Busy are high in the cycle after e.
- Ack and Done are registered pulses, each exactly one cycle wide.
- Each divisor tried costs WIDTH + 2 cycles.
- With k divisors divided:
  - Composite: Done after edge e + k·(WIDTH+2).
  - Prime, or N < 2 (k = 0): Done after edge e + k·(WIDTH+2) + 1.
- After Done, IDLE can accept a new request on the next edge. Minimum spacing is 1 idle cycle.
- Requests never pre-empt a running test. No request is lost while Req is held.

## Structure
- Package prime_pkg holds:
  - the state enum {IDLE, CHECK, DIV, EVAL};
  - the default WIDTH;
  - COUNT_W = 8.
- Sub-module prime_modunit computes N mod d by restoring division:
  - one quotient bit per cycle;
  - start pulse in; done pulse and rem out after WIDTH cycles;
  - async reset to idle.
- The arbiter, FSM, d register, and counters stay in the top module.

## Test plan
- Port 0 Num = 2 accepted at edge e -> Done after e+1, Prime = 1, DoneId = 0, PrimeCount0 = 1.
- Port 1 Num = 4 -> Done after e+12, Prime = 0, DoneId = 1, PrimeCount1 unchanged.
- Port 0 Num = 997 -> 30 divisions (d = 2..31), Done after e+361, Prime = 1. Num = 961 -> Done with Prime = 0 after the d = 31 division.
- Num = 0, then Num = 1 -> each Done after e+1 with Prime = 0.
- Req0 and Req1 both high out of reset (Num0 = 7, Num1 = 9):
  - Ack0 first; Ack1 on the edge after Done; Prime 1 then 0.
  - With both held, grants then alternate 0, 1, 0, 1.
- Reset asserted during DIV -> all outputs 0 at once and no Done. A re-raised request then completes with the normal latency.
